mem_host_loader: RTL

- Host-side initiator for the processor's external memory-access interface.
- Accepts a byte stream (from a UART receiver) carrying commands to:
  - load IRAM/DRAM words,
  - read DRAM words back,
  - start or stop the core.
- Drives the start/start_2/start_3/start_4 strobe, address, data and enable lines with the required hold timing.
- Returns response bytes on an outbound byte stream.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/loader_frame_collect.sv | 49 ++++
 rtl/mem_host_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared command codes, FSM state encoding, frame field selectors and default
// response bytes for mem_host_loader.
package loader_pkg;

   localparam logic [7:0] CMD_WR_IRAM = 8'h01;
   localparam logic [7:0] CMD_WR_DRAM = 8'h02;
   localparam logic [7:0] CMD_RD_DRAM = 8'h03;
   localparam logic [7:0] CMD_RUN     = 8'h04;
   localparam logic [7:0] CMD_STOP    = 8'h05;
   localparam logic [7:0] CMD_CSUM    = 8'h06;

   localparam logic [7:0] ACK_DEFAULT = 8'hA5;
   localparam logic [7:0] ERR_DEFAULT = 8'hEE;

   localparam logic [1:0] FLD_A1 = 2'd0;
   localparam logic [1:0] FLD_A0 = 2'd1;
   localparam logic [1:0] FLD_D1 = 2'd2;
   localparam logic [1:0] FLD_D0 = 2'd3;

   typedef enum logic [3:0] {
      IDLE, GET_A1, GET_A0, GET_D1, GET_D0,
      WR_HOLD, WR_REL, RD_HOLD, RD_WAIT,
      TX_HI, TX_LO, TX_ONE
   } loader_state_t;

endpackage

// File: rtl/loader_frame_collect.sv
// Assembles the address and data fields of a command frame from the byte stream;
// exposes the post-shift values so the FSM can drive them on the completing byte.
module loader_frame_collect
   import loader_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              take,
   input  logic [1:0]        field,
   input  logic              last,
   input  logic [7:0]        rx_byte,
   output logic [ADDR_W-1:0] addr_next,
   output logic [DATA_W-1:0] data_next,
   output logic [ADDR_W-1:0] addr,
   output logic              complete
);

   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;

   // A1 only contributes the address bits above bit 7; the rest of that byte is ignored
   always_comb begin
      addr_next = addr_reg;
      data_next = data_reg;
      case (field)
         FLD_A1:  addr_next = {rx_byte[ADDR_W-9:0], addr_reg[7:0]};
         FLD_A0:  addr_next = {addr_reg[ADDR_W-1:8], rx_byte};
         FLD_D1:  data_next = {rx_byte, data_reg[7:0]};
         default: data_next = {data_reg[DATA_W-1:8], rx_byte};
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_reg <= '0;
         data_reg <= '0;
      end else if (take) begin
         addr_reg <= addr_next;
         data_reg <= data_next;
      end
   end

   assign addr     = addr_reg;
   assign complete = take & last;

endmodule

// File: rtl/mem_host_loader.sv
// Byte-stream host loader driving the core's external IRAM/DRAM access strobes.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of written words (command 0x06).
module mem_host_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W      = 9,
   parameter int         DATA_W      = 16,
   parameter int         HOLD_CYCLES = 3,
   parameter int         READ_LAT    = 2,
   parameter logic [7:0] ACK_BYTE    = ACK_DEFAULT,
   parameter logic [7:0] ERR_BYTE    = ERR_DEFAULT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              start,
   output logic              start_2,
   output logic              start_3,
   output logic              start_4,
   output logic [ADDR_W-1:0] addr_ext,
   output logic              iram_write_ext,
   output logic [DATA_W-1:0] Data_in_ins,
   output logic              dram_write_ext,
   output logic [DATA_W-1:0] Data_in_dram,
   output logic              read_en_ext,
   input  logic [DATA_W-1:0] dram_in
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] LAT_LAST  = 8'(READ_LAT - 1);

   loader_state_t     state;
   logic [7:0]        cmd_reg;
   logic [7:0]        cnt;
   logic [7:0]        rd_lo;
   logic              running;
   logic              rx_fire;
   logic              tx_fire;
   logic              take;
   logic              last;
   logic              complete;
   logic [1:0]        field;
   logic [ADDR_W-1:0] addr_next;
   logic [ADDR_W-1:0] frame_addr;
   logic [DATA_W-1:0] data_next;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   assign rx_fire = rx_valid & rx_ready;
   assign tx_fire = tx_valid & tx_ready;
   assign take    = rx_fire & (state != IDLE);
   assign start   = running;

   always_comb begin
      field = FLD_A1;
      last  = 1'b0;
      case (state)
         GET_A0: begin field = FLD_A0; last = (cmd_reg == CMD_RD_DRAM); end
         GET_D1: field = FLD_D1;
         GET_D0: begin field = FLD_D0; last = 1'b1; end
         default: ;
      endcase
   end

   loader_frame_collect #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_collect (
      .clock     (clock),
      .reset_n   (reset_n),
      .take      (take),
      .field     (field),
      .last      (last),
      .rx_byte   (rx_data),
      .addr_next (addr_next),
      .data_next (data_next),
      .addr      (frame_addr),
      .complete  (complete)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cmd_reg        <= '0;
         cnt            <= '0;
         rd_lo          <= '0;
         running        <= 1'b0;
         rx_ready       <= 1'b1;
         tx_valid       <= 1'b0;
         tx_data        <= '0;
         start_2        <= 1'b0;
         start_3        <= 1'b0;
         start_4        <= 1'b0;
         addr_ext       <= '0;
         iram_write_ext <= 1'b0;
         Data_in_ins    <= '0;
         dram_write_ext <= 1'b0;
         Data_in_dram   <= '0;
         read_en_ext    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum           <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (rx_fire) begin
               cmd_reg  <= rx_data;
               // default is a one-byte reply; commands below override the byte or the path
               state    <= TX_ONE;
               rx_ready <= 1'b0;
               tx_valid <= 1'b1;
               tx_data  <= ERR_BYTE;
               case (rx_data)
                  CMD_WR_IRAM, CMD_WR_DRAM, CMD_RD_DRAM:
                     if (!running) begin
                        state    <= GET_A1;
                        rx_ready <= 1'b1;
                        tx_valid <= 1'b0;
                     end
                  CMD_RUN:  begin running <= 1'b1; tx_data <= ACK_BYTE; end
                  CMD_STOP: begin running <= 1'b0; tx_data <= ACK_BYTE; end
`ifdef LOADER_CHECKSUM_EN
                  CMD_CSUM: begin
                     rd_lo   <= csum[7:0];
                     tx_data <= csum[DATA_W-1 -: 8];
                     state   <= TX_HI;
                  end
`endif
                  default: ;
               endcase
            end
            GET_A1: if (rx_fire) state <= GET_A0;
            GET_A0: if (complete) begin
               state       <= RD_HOLD;
               rx_ready    <= 1'b0;
               cnt         <= '0;
               addr_ext    <= addr_next;
               start_4     <= 1'b1;
               read_en_ext <= 1'b1;
            end else if (rx_fire) begin
               state <= GET_D1;
            end
            GET_D1: if (rx_fire) state <= GET_D0;
            GET_D0: if (complete) begin
               state    <= WR_HOLD;
               rx_ready <= 1'b0;
               cnt      <= '0;
               addr_ext <= frame_addr;
               if (cmd_reg == CMD_WR_IRAM) begin
                  start_2        <= 1'b1;
                  iram_write_ext <= 1'b1;
                  Data_in_ins    <= data_next;
               end else begin
                  start_3        <= 1'b1;
                  dram_write_ext <= 1'b1;
                  Data_in_dram   <= data_next;
               end
            end
            WR_HOLD: begin
               cnt <= cnt + 8'd1;
               if (cnt == HOLD_LAST) begin
                  state          <= WR_REL;
                  start_2        <= 1'b0;
                  start_3        <= 1'b0;
                  iram_write_ext <= 1'b0;
                  dram_write_ext <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  csum           <= csum ^ (start_2 ? Data_in_ins : Data_in_dram);
`endif
               end
            end
            WR_REL: begin
               state        <= TX_ONE;
               addr_ext     <= '0;
               Data_in_ins  <= '0;
               Data_in_dram <= '0;
               tx_valid     <= 1'b1;
               tx_data      <= ACK_BYTE;
            end
            RD_HOLD: begin
               cnt <= cnt + 8'd1;
               if (cnt == HOLD_LAST) begin
                  state       <= RD_WAIT;
                  cnt         <= '0;
                  start_4     <= 1'b0;
                  read_en_ext <= 1'b0;
               end
            end
            RD_WAIT: begin
               cnt <= cnt + 8'd1;
               if (cnt == LAT_LAST) begin
                  state    <= TX_HI;
                  addr_ext <= '0;
                  rd_lo    <= dram_in[7:0];
                  tx_data  <= dram_in[DATA_W-1 -: 8];
                  tx_valid <= 1'b1;
               end
            end
            TX_HI: if (tx_fire) begin
               tx_data <= rd_lo;
               state   <= TX_LO;
            end
            TX_LO, TX_ONE: if (tx_fire) begin
               tx_valid <= 1'b0;
               rx_ready <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
